// File: rtl/ts_stream_source_pkg.sv
// ts_gen_pkg: MPEG-2 TS packet constants and header-byte helper shared by the stream source.
// Pure declarations; no latency or backpressure of its own.
package ts_gen_pkg;

    localparam logic [7:0] TS_SYNC_BYTE   = 8'h47;
    localparam int         TS_PKT_LEN     = 188;
    localparam int         TS_HDR_LEN     = 4;
    localparam logic [7:0] TS_LAST_IDX    = 8'(TS_PKT_LEN - 1);
    localparam logic       TS_PUSI        = 1'b1;
    localparam logic [1:0] TS_AFC_PAYLOAD = 2'b01;

    // Byte 1: TEI=0, PUSI, priority=0, PID[12:8]
    function automatic logic [7:0] ts_hdr_byte1(input logic [12:0] pid);
        return {1'b0, TS_PUSI, 1'b0, pid[12:8]};
    endfunction

endpackage

// File: rtl/ts_stream_source_if.sv
// Bundle of the four lock-stepped TS byte streams plus the enable that paces them.
// Registered outputs, one cycle after an enabled edge; enable low freezes the streams.
interface ts_stream_source_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  enable;
    logic                  byte_valid;
    logic                  byte_sop;
    logic [DATA_WIDTH-1:0] byte_data1;
    logic [DATA_WIDTH-1:0] byte_data2;
    logic [DATA_WIDTH-1:0] byte_data3;
    logic [DATA_WIDTH-1:0] byte_data4;

    modport master (
        input  enable,
        output byte_valid, byte_sop, byte_data1, byte_data2, byte_data3, byte_data4
    );

    modport slave (
        output enable,
        input  byte_valid, byte_sop, byte_data1, byte_data2, byte_data3, byte_data4
    );
endinterface

// File: rtl/ts_stream_source_channel.sv
// ts_channel_gen: one TS channel; owns its continuity counter and output byte register.
// One-cycle registered byte; holds byte and cc while enable is low.
module ts_channel_gen
    import ts_gen_pkg::*;
#(
    parameter int          DATA_WIDTH = 8,
    parameter logic [12:0] PID        = 13'h100
) (
    input  logic                  core_clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [7:0]            idx,
    input  logic [7:0]            pkt,
    input  logic                  pkt_end,
    input  logic                  skip,
    output logic [DATA_WIDTH-1:0] byte_data
);

    logic [3:0] cc;
    logic [3:0] cc_step;
    logic [7:0] byte_nxt;

    always_comb begin
        // Payload is a ramp offset by the packet counter, wrapping mod 256
        byte_nxt = idx + pkt;
        case (idx)
            8'd0:    byte_nxt = TS_SYNC_BYTE;
            8'd1:    byte_nxt = ts_hdr_byte1(PID);
            8'd2:    byte_nxt = PID[7:0];
            8'd3:    byte_nxt = {2'b00, TS_AFC_PAYLOAD, cc};
            default: ;
        endcase
    end

    assign cc_step = skip ? 4'd2 : 4'd1;

    always_ff @(posedge core_clk) begin
        if (reset) begin
            cc        <= 4'd0;
            byte_data <= '0;
        end else if (enable) begin
            byte_data <= byte_nxt;
            if (pkt_end) begin
                cc <= cc + cc_step;
            end
        end
    end

endmodule

// File: rtl/ts_stream_source.sv
// Four-channel 188-byte TS source; byte registered one cycle after each enabled edge, enable low freezes.
// Optional per-channel CC skipping (one lost packet per channel per LOSS_PERIOD) under TS_LOSS_INJECT_EN.
module ts_stream_source
    import ts_gen_pkg::*;
#(
    parameter int          DATA_WIDTH  = 8,
    parameter logic [12:0] PID_BASE    = 13'h100,
    parameter int          LOSS_PERIOD = 16
) (
    input  logic                core_clk,
    input  logic                reset,
    ts_stream_source_if.master  bus
);

    logic [7:0]            idx;
    logic [7:0]            pkt;
    logic                  pkt_end;
    logic [3:0]            skip;
    logic [DATA_WIDTH-1:0] ch_data [4];

    assign pkt_end = bus.enable && (idx == TS_LAST_IDX);

    always_ff @(posedge core_clk) begin
        if (reset) begin
            idx            <= 8'd0;
            pkt            <= 8'd0;
            bus.byte_valid <= 1'b0;
            bus.byte_sop   <= 1'b0;
        end else begin
            bus.byte_valid <= bus.enable;
            bus.byte_sop   <= bus.enable && (idx == 8'd0);
            if (bus.enable) begin
                if (idx == TS_LAST_IDX) begin
                    idx <= 8'd0;
                    pkt <= pkt + 8'd1;
                end else begin
                    idx <= idx + 8'd1;
                end
            end
        end
    end

`ifdef TS_LOSS_INJECT_EN
    localparam logic [7:0] LP_LAST = 8'(LOSS_PERIOD - 1);
    logic [7:0] lp;

    always_ff @(posedge core_clk) begin
        if (reset) begin
            lp <= 8'd0;
        end else if (pkt_end) begin
            lp <= (lp == LP_LAST) ? 8'd0 : lp + 8'd1;
        end
    end
`endif

    for (genvar k = 0; k < 4; k++) begin : g_ch
`ifdef TS_LOSS_INJECT_EN
        // Channel k drops a CC value after the packet where lp == k, staggering losses
        assign skip[k] = (lp == 8'(k));
`else
        assign skip[k] = 1'b0;
`endif
        ts_channel_gen #(
            .DATA_WIDTH (DATA_WIDTH),
            .PID        (PID_BASE + 13'(k))
        ) u_ch (
            .core_clk  (core_clk),
            .reset     (reset),
            .enable    (bus.enable),
            .idx       (idx),
            .pkt       (pkt),
            .pkt_end   (pkt_end),
            .skip      (skip[k]),
            .byte_data (ch_data[k])
        );
    end

    assign bus.byte_data1 = ch_data[0];
    assign bus.byte_data2 = ch_data[1];
    assign bus.byte_data3 = ch_data[2];
    assign bus.byte_data4 = ch_data[3];

endmodule

// File: tb/tb_ts_stream_source.sv
// Scoreboard bench for ts_stream_source: a posedge model queues expected bytes, a negedge monitor pops and compares.
module tb_ts_stream_source;

    localparam int LP = 4;

    logic core_clk = 1'b0;
    logic reset    = 1'b1;

    ts_stream_source_if #(.DATA_WIDTH(8)) bus ();

    ts_stream_source #(
        .DATA_WIDTH  (8),
        .PID_BASE    (13'h100),
        .LOSS_PERIOD (LP)
    ) dut (
        .core_clk (core_clk),
        .reset    (reset),
        .bus      (bus.master)
    );

    always #5 core_clk = ~core_clk;

    typedef struct packed {
        logic       sop;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [7:0] d3;
        logic [7:0] d4;
    } obs_t;

    obs_t sb[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- reference model (posedge) ----------------
    int         m_idx = 0;
    int         m_pkt = 0;
    int         m_lp  = 0;
    logic [3:0] m_cc [4];
    bit         rst_seen = 1'b1;

    function automatic logic [7:0] exp_byte(input int k);
        case (m_idx)
            0:       return 8'h47;
            1:       return 8'h41;
            2:       return 8'(k);
            3:       return {4'h1, m_cc[k]};
            default: return 8'((m_idx + m_pkt) % 256);
        endcase
    endfunction

    always @(posedge core_clk) begin
        obs_t e;
        rst_seen = reset;
        if (reset) begin
            m_idx = 0;
            m_pkt = 0;
            m_lp  = 0;
            for (int k = 0; k < 4; k++) m_cc[k] = 4'd0;
            sb.delete();
        end else if (bus.enable) begin
            e.sop = (m_idx == 0);
            e.d1  = exp_byte(0);
            e.d2  = exp_byte(1);
            e.d3  = exp_byte(2);
            e.d4  = exp_byte(3);
            sb.push_back(e);
            if (m_idx == 187) begin
                m_idx = 0;
                m_pkt = (m_pkt + 1) % 256;
                for (int k = 0; k < 4; k++) begin
`ifdef TS_LOSS_INJECT_EN
                    m_cc[k] = m_cc[k] + ((m_lp == k) ? 4'd2 : 4'd1);
`else
                    m_cc[k] = m_cc[k] + 4'd1;
`endif
                end
                m_lp = (m_lp + 1) % LP;
            end else begin
                m_idx++;
            end
        end
    end

    // ---------------- monitor (negedge) ----------------
    int         vcount = 0;
    int         pidx   = -1;
    int         bpos   = 0;
    logic [7:0] last [4];
    logic [7:0] hdr0 [4][4];
    logic [7:0] hdr3 [4][32];
    logic [7:0] pay4   [32];
    logic [7:0] pay187 [32];
    int         sop_at [32];

    always @(negedge core_clk) begin
        logic [7:0] d [4];
        obs_t       e;
        d[0] = bus.byte_data1;
        d[1] = bus.byte_data2;
        d[2] = bus.byte_data3;
        d[3] = bus.byte_data4;
        if (rst_seen) begin
            chk("reset_state", {bus.byte_valid, bus.byte_sop, d[0], d[1], d[2], d[3]}, 34'd0);
            vcount = 0;
            pidx   = -1;
            bpos   = 0;
            for (int k = 0; k < 4; k++) last[k] = 8'd0;
        end else if (bus.byte_valid === 1'b1) begin
            if (bus.byte_sop === 1'b1) begin
                pidx++;
                bpos = 0;
                if (pidx < 32) sop_at[pidx] = vcount;
            end
            if (pidx >= 0 && pidx < 32) begin
                for (int k = 0; k < 4; k++) begin
                    if (pidx == 0 && bpos < 4) hdr0[k][bpos] = d[k];
                    if (bpos == 3) hdr3[k][pidx] = d[k];
                end
                if (bpos == 4)   pay4[pidx]   = d[0];
                if (bpos == 187) pay187[pidx] = d[0];
            end
            if (sb.size() == 0) begin
                chk("sb_underflow", {bus.byte_sop, d[0], d[1], d[2], d[3]}, 33'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_byte", {bus.byte_sop, d[0], d[1], d[2], d[3]}, e);
            end
            for (int k = 0; k < 4; k++) last[k] = d[k];
            bpos++;
            vcount++;
        end else begin
            chk("idle_frozen", {bus.byte_valid, d[0], d[1], d[2], d[3]},
                {1'b0, last[0], last[1], last[2], last[3]});
        end
    end

    // ---------------- stimulus ----------------
    task automatic run(input int n);
        repeat (n) @(posedge core_clk);
        #1;
    endtask

    int cc_exp [4][3];

    initial begin
`ifdef TS_LOSS_INJECT_EN
        cc_exp = '{'{0, 2, 3}, '{0, 1, 3}, '{0, 1, 2}, '{0, 1, 2}};
`else
        cc_exp = '{'{0, 1, 2}, '{0, 1, 2}, '{0, 1, 2}, '{0, 1, 2}};
`endif
        bus.enable = 1'b0;
        reset      = 1'b1;
        run(3);
        reset = 1'b0;
        run(2);

        // Three full packets, then 50 bytes into the fourth (pkt=3, idx=50)
        bus.enable = 1'b1;
        run(564 + 50);

        chk("ch1_b0", hdr0[0][0], 8'h47);
        chk("ch1_b1", hdr0[0][1], 8'h41);
        chk("ch1_b2", hdr0[0][2], 8'h00);
        chk("ch1_b3", hdr0[0][3], 8'h10);
        chk("ch4_b0", hdr0[3][0], 8'h47);
        chk("ch4_b1", hdr0[3][1], 8'h41);
        chk("ch4_b2", hdr0[3][2], 8'h03);
        chk("ch4_b3", hdr0[3][3], 8'h10);
        chk("p0_byte4",   pay4[0],   8'h04);
        chk("p0_byte187", pay187[0], 8'hBB);
        chk("p1_byte4",   pay4[1],   8'h05);
        chk("sop_p0", sop_at[0], 0);
        chk("sop_p1", sop_at[1], 188);
        chk("sop_p2", sop_at[2], 376);
        chk("sop_count", pidx, 3);
        for (int k = 0; k < 4; k++)
            for (int p = 0; p < 3; p++)
                chk($sformatf("cc_ch%0d_p%0d", k + 1, p), hdr3[k][p], {4'h1, 4'(cc_exp[k][p])});

        // Enable gap at idx=50
        bus.enable = 1'b0;
        run(10);
        chk("gap_valid", bus.byte_valid, 1'b0);
        chk("gap_frozen", bus.byte_data1, 8'h34);
        bus.enable = 1'b1;
        run(1);
        chk("resume_valid", bus.byte_valid, 1'b1);
        chk("resume_ch1", bus.byte_data1, 8'h35);
        chk("resume_ch4", bus.byte_data4, 8'h35);
        run(49);

        // Reset at idx=100 with enable still high; reset must win
        reset = 1'b1;
        run(2);
        chk("rst_valid", bus.byte_valid, 1'b0);
        reset = 1'b0;
        run(17 * 188 + 4);

        chk("rst_sop", sop_at[0], 0);
        chk("rst_b0", hdr0[0][0], 8'h47);
        chk("rst_cc0", hdr3[0][0], 8'h10);
        chk("rst_pkt0", pay4[0], 8'h04);
        for (int p = 0; p < 17; p++)
            chk($sformatf("pkt_mono_p%0d", p), pay4[p], 8'(4 + p));
`ifndef TS_LOSS_INJECT_EN
        chk("cc_p15", hdr3[0][15], 8'h1F);
        chk("cc_wrap_p16", hdr3[0][16], 8'h10);
        chk("cc_wrap_ch4_p16", hdr3[3][16], 8'h10);
`endif

        bus.enable = 1'b0;
        run(2);
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
